// File: rtl/execute_stage.sv
// execute_stage: ID/EX consumer. Captures a decoded instruction on a rising
// i_dec_ins_ready, runs the ALU, holds the result in EX/MEM until
// i_mem_ack, then pulses o_flush so the decoder can release ID/EX.
module execute_stage #(
    parameter int XLEN  = 32,
    parameter int OP_W  = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [XLEN-1:0]  i_operand1,
    input  logic [XLEN-1:0]  i_operand2,
    input  logic [OP_W-1:0]  i_ALUop,
    input  logic             i_mem_read,
    input  logic             i_mem_write,
    input  logic [4:0]       i_rd,
    input  logic             i_dec_ins_ready,
    input  logic             i_mem_ack,
    output logic             o_flush,
    output logic [XLEN-1:0]  o_result,
    output logic [XLEN-1:0]  o_store_data,
    output logic [4:0]       o_rd,
    output logic             o_mem_read,
    output logic             o_mem_write,
    output logic             o_reg_write,
    output logic             o_ex_valid,
    output logic             o_illegal,
    output logic [CNT_W-1:0] o_ex_count
);

    localparam logic [OP_W-1:0] OP_ADD   = OP_W'(0);
    localparam logic [OP_W-1:0] OP_SUB   = OP_W'(1);
    localparam logic [OP_W-1:0] OP_XOR   = OP_W'(2);
    localparam logic [OP_W-1:0] OP_OR    = OP_W'(3);
    localparam logic [OP_W-1:0] OP_AND   = OP_W'(4);
    localparam logic [OP_W-1:0] OP_SLL   = OP_W'(5);
    localparam logic [OP_W-1:0] OP_SRL   = OP_W'(6);
    localparam logic [OP_W-1:0] OP_SRA   = OP_W'(7);
    localparam logic [OP_W-1:0] OP_SLT   = OP_W'(8);
    localparam logic [OP_W-1:0] OP_SLTU  = OP_W'(9);
    localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(10);
    localparam logic [OP_W-1:0] OP_XORI  = OP_W'(11);
    localparam logic [OP_W-1:0] OP_ORI   = OP_W'(12);
    localparam logic [OP_W-1:0] OP_ANDI  = OP_W'(13);
    localparam logic [OP_W-1:0] OP_SLLI  = OP_W'(14);
    localparam logic [OP_W-1:0] OP_SRLI  = OP_W'(15);
    localparam logic [OP_W-1:0] OP_SRAI  = OP_W'(16);
    localparam logic [OP_W-1:0] OP_SLTI  = OP_W'(17);
    localparam logic [OP_W-1:0] OP_SLTIU = OP_W'(18);
    localparam logic [OP_W-1:0] OP_SW    = OP_W'(20);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CAPTURE,
        S_EXEC,
        S_HOLD,
        S_FLUSH
    } state_t;

    state_t r_state;
    state_t w_next;

    logic             r_prev;
    logic             w_rise;

    logic [XLEN-1:0]  r_op1;
    logic [XLEN-1:0]  r_op2;
    logic [OP_W-1:0]  r_op;
    logic             r_mr;
    logic             r_mw;
    logic [4:0]       r_rd_l;

    logic [XLEN-1:0]  r_result;
    logic [XLEN-1:0]  r_store_data;
    logic [4:0]       r_rd;
    logic             r_mem_read;
    logic             r_mem_write;
    logic             r_reg_write;
    logic             r_ex_valid;
    logic             r_illegal;
    logic [CNT_W-1:0] r_count;

    logic [XLEN-1:0]  w_imm;
    logic [XLEN-1:0]  w_b;
    logic [4:0]       w_sh;
    logic [XLEN-1:0]  w_alu;
    logic [XLEN-1:0]  w_store;
    logic             w_legal;
    logic             w_reg_write;

    assign w_rise = i_dec_ins_ready & ~r_prev;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; a rise outside IDLE is simply dropped
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (w_rise) w_next = S_CAPTURE;
            S_CAPTURE: w_next = S_EXEC;
            S_EXEC:    w_next = S_HOLD;
            S_HOLD:    if (i_mem_ack) w_next = S_FLUSH;
            S_FLUSH:   w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // ALU on the latched ID/EX values; immediate ops reuse the register-op datapath with sext12 B
    always_comb begin
        w_imm   = {{(XLEN-12){r_op2[11]}}, r_op2[11:0]};
        w_b     = r_op2;
        w_alu   = '0;
        w_store = '0;
        w_legal = 1'b1;
        if (r_op >= OP_ADDI && r_op <= OP_SLTIU) begin
            w_b = w_imm;
        end
        w_sh = w_b[4:0];
        case (r_op)
            OP_ADD,  OP_ADDI:  w_alu = r_op1 + w_b;
            OP_SUB:            w_alu = r_op1 - w_b;
            OP_XOR,  OP_XORI:  w_alu = r_op1 ^ w_b;
            OP_OR,   OP_ORI:   w_alu = r_op1 | w_b;
            OP_AND,  OP_ANDI:  w_alu = r_op1 & w_b;
            OP_SLL,  OP_SLLI:  w_alu = r_op1 << w_sh;
            OP_SRL,  OP_SRLI:  w_alu = r_op1 >> w_sh;
            OP_SRA,  OP_SRAI:  w_alu = XLEN'($signed(r_op1) >>> w_sh);
            OP_SLT,  OP_SLTI:  w_alu = {{(XLEN-1){1'b0}}, ($signed(r_op1) < $signed(w_b))};
            OP_SLTU, OP_SLTIU: w_alu = {{(XLEN-1){1'b0}}, (r_op1 < w_b)};
            OP_SW:             w_store = r_op2;
            default:           w_legal = 1'b0;
        endcase
        w_reg_write = w_legal & ~r_mw & (r_rd_l != 5'd0);
    end

    // Edge detect, ID/EX capture, EX/MEM load and retire counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev       <= 1'b0;
            r_op1        <= '0;
            r_op2        <= '0;
            r_op         <= '0;
            r_mr         <= 1'b0;
            r_mw         <= 1'b0;
            r_rd_l       <= '0;
            r_result     <= '0;
            r_store_data <= '0;
            r_rd         <= '0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_reg_write  <= 1'b0;
            r_ex_valid   <= 1'b0;
            r_illegal    <= 1'b0;
            r_count      <= '0;
        end else begin
            r_prev <= i_dec_ins_ready;
            case (r_state)
                S_CAPTURE: begin
                    r_op1     <= i_operand1;
                    r_op2     <= i_operand2;
                    r_op      <= i_ALUop;
                    r_mr      <= i_mem_read;
                    r_mw      <= i_mem_write;
                    r_rd_l    <= i_rd;
                    r_illegal <= 1'b0;
                end
                S_EXEC: begin
                    r_result     <= w_alu;
                    r_store_data <= w_store;
                    r_rd         <= r_rd_l;
                    r_mem_read   <= r_mr;
                    r_mem_write  <= r_mw;
                    r_reg_write  <= w_reg_write;
                    r_illegal    <= ~w_legal;
                    r_ex_valid   <= 1'b1;
                end
                S_HOLD: begin
                    if (i_mem_ack) begin
                        r_ex_valid <= 1'b0;
                        r_count    <= r_count + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_flush      = (r_state == S_FLUSH);
    assign o_result     = r_result;
    assign o_store_data = r_store_data;
    assign o_rd         = r_rd;
    assign o_mem_read   = r_mem_read;
    assign o_mem_write  = r_mem_write;
    assign o_reg_write  = r_reg_write;
    assign o_ex_valid   = r_ex_valid;
    assign o_illegal    = r_illegal;
    assign o_ex_count   = r_count;

endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage: directed and random instructions checked against an
// arithmetic reference model of the execute stage.
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] i_operand1;
    logic [31:0] i_operand2;
    logic [4:0]  i_ALUop;
    logic        i_mem_read;
    logic        i_mem_write;
    logic [4:0]  i_rd;
    logic        i_dec_ins_ready;
    logic        i_mem_ack;
    logic        o_flush;
    logic [31:0] o_result;
    logic [31:0] o_store_data;
    logic [4:0]  o_rd;
    logic        o_mem_read;
    logic        o_mem_write;
    logic        o_reg_write;
    logic        o_ex_valid;
    logic        o_illegal;
    logic [15:0] o_ex_count;

    int passed = 0;
    int total  = 0;
    int fails  = 0;
    int exp_count = 0;

    typedef struct packed {
        logic [31:0] res;
        logic [31:0] sd;
        logic        rw;
        logic        ill;
    } exp_t;

    execute_stage #(.XLEN(32), .OP_W(5), .CNT_W(16)) dut (
        .clk             (clk),
        .rst             (rst),
        .i_operand1      (i_operand1),
        .i_operand2      (i_operand2),
        .i_ALUop         (i_ALUop),
        .i_mem_read      (i_mem_read),
        .i_mem_write     (i_mem_write),
        .i_rd            (i_rd),
        .i_dec_ins_ready (i_dec_ins_ready),
        .i_mem_ack       (i_mem_ack),
        .o_flush         (o_flush),
        .o_result        (o_result),
        .o_store_data    (o_store_data),
        .o_rd            (o_rd),
        .o_mem_read      (o_mem_read),
        .o_mem_write     (o_mem_write),
        .o_reg_write     (o_reg_write),
        .o_ex_valid      (o_ex_valid),
        .o_illegal       (o_illegal),
        .o_ex_count      (o_ex_count)
    );

    always #5 clk = ~clk;

    // Reference: immediate ops 10..18 behave as register ops {ADD,XOR,OR,AND,SLL,SRL,SRA,SLT,SLTU}
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] op2,
                                   input int op, input logic mw, input logic [4:0] rd);
        int          imap [9] = '{0, 2, 3, 4, 5, 6, 7, 8, 9};
        int          base;
        logic [31:0] b;
        logic [63:0] wide;
        int          sh;
        exp_t        e;
        e = '0;
        if (op >= 10 && op <= 18) begin
            base = imap[op - 10];
            b    = {{20{op2[11]}}, op2[11:0]};
        end else begin
            base = op;
            b    = op2;
        end
        sh = int'(b % 32);
        case (base)
            0: e.res = a + b;
            1: e.res = a - b;
            2: e.res = a ^ b;
            3: e.res = a | b;
            4: e.res = a & b;
            5: e.res = a * (32'd1 << sh);
            6: e.res = a / (32'd1 << sh);
            7: begin
                wide  = {{32{a[31]}}, a};
                wide  = wide >> sh;
                e.res = wide[31:0];
            end
            8: e.res = ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
            9: e.res = (a < b) ? 32'd1 : 32'd0;
            20: e.sd = op2;
            default: e.ill = 1'b1;
        endcase
        e.rw = !e.ill && !mw && (rd != 5'd0);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full handshake; dbl re-raises i_dec_ins_ready during HOLD, which must be ignored
    task automatic run(input logic [31:0] a, input logic [31:0] b, input int op,
                       input logic mr, input logic mw, input logic [4:0] rd,
                       input int hold, input bit dbl,
                       input bit use_lit, input logic [31:0] lit);
        exp_t        e;
        logic [31:0] held;
        e = model(a, b, op, mw, rd);
        i_operand1 = a; i_operand2 = b; i_ALUop = 5'(op);
        i_mem_read = mr; i_mem_write = mw; i_rd = rd;
        i_dec_ins_ready = 1'b1;
        step();
        chk("capture_valid", {31'd0, o_ex_valid}, 32'd0);
        step();
        chk("exec_valid", {31'd0, o_ex_valid}, 32'd0);
        i_operand1 = $urandom; i_operand2 = $urandom; i_ALUop = 5'($urandom);
        step();
        chk("valid", {31'd0, o_ex_valid}, 32'd1);
        chk("result", o_result, e.res);
        chk("store_data", o_store_data, e.sd);
        chk("rd", {27'd0, o_rd}, {27'd0, rd});
        chk("mem_read", {31'd0, o_mem_read}, {31'd0, mr});
        chk("mem_write", {31'd0, o_mem_write}, {31'd0, mw});
        chk("reg_write", {31'd0, o_reg_write}, {31'd0, e.rw});
        chk("illegal", {31'd0, o_illegal}, {31'd0, e.ill});
        chk("no_flush", {31'd0, o_flush}, 32'd0);
        if (use_lit) chk("plan_result", o_result, lit);
        held = o_result;
        for (int k = 0; k < hold; k++) begin
            if (dbl && k == 0) i_dec_ins_ready = 1'b0;
            if (dbl && k == 1) i_dec_ins_ready = 1'b1;
            step();
            chk("hold_flush", {31'd0, o_flush}, 32'd0);
            chk("hold_valid", {31'd0, o_ex_valid}, 32'd1);
            chk("hold_result", o_result, held);
        end
        i_mem_ack = 1'b1;
        step();
        i_mem_ack = 1'b0;
        exp_count = (exp_count + 1) % 65536;
        chk("flush", {31'd0, o_flush}, 32'd1);
        chk("ack_valid", {31'd0, o_ex_valid}, 32'd0);
        chk("count", {16'd0, o_ex_count}, exp_count);
        if (dbl) begin
            for (int k = 0; k < 4; k++) begin
                step();
                chk("no_restart_valid", {31'd0, o_ex_valid}, 32'd0);
                chk("no_restart_flush", {31'd0, o_flush}, 32'd0);
            end
            i_dec_ins_ready = 1'b0;
            step();
        end else begin
            i_dec_ins_ready = 1'b0;
            step();
            chk("flush_once", {31'd0, o_flush}, 32'd0);
        end
    endtask

    initial begin
        int          op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        rst = 1'b1;
        i_operand1 = '0; i_operand2 = '0; i_ALUop = '0;
        i_mem_read = 1'b0; i_mem_write = 1'b0; i_rd = '0;
        i_dec_ins_ready = 1'b0; i_mem_ack = 1'b0;
        step();
        step();
        chk("rst_valid", {31'd0, o_ex_valid}, 32'd0);
        chk("rst_result", o_result, 32'd0);
        chk("rst_count", {16'd0, o_ex_count}, 32'd0);
        chk("rst_flush", {31'd0, o_flush}, 32'd0);
        rst = 1'b0;
        step();

        run(32'd5,        32'd7,        0,  1'b0, 1'b0, 5'd3, 2,  1'b0, 1'b1, 32'd12);
        run(32'hFFFFFFFF, 32'd1,        1,  1'b0, 1'b0, 5'd4, 0,  1'b0, 1'b1, 32'hFFFFFFFE);
        run(32'hFFFFFFFF, 32'd1,        8,  1'b0, 1'b0, 5'd5, 0,  1'b0, 1'b1, 32'd1);
        run(32'hFFFFFFFF, 32'd1,        9,  1'b0, 1'b0, 5'd6, 0,  1'b0, 1'b1, 32'd0);
        run(32'd10,       32'h00000FFF, 10, 1'b0, 1'b0, 5'd7, 1,  1'b0, 1'b1, 32'd9);
        run(32'h80000000, 32'h00000404, 16, 1'b0, 1'b0, 5'd1, 0,  1'b0, 1'b1, 32'hF8000000);
        run(32'h80000000, 32'h00000004, 15, 1'b0, 1'b0, 5'd1, 0,  1'b0, 1'b1, 32'h08000000);
        run(32'h00001000, 32'hDEADBEEF, 20, 1'b0, 1'b1, 5'd8, 10, 1'b0, 1'b1, 32'd0);
        chk("sw_store_data", o_store_data, 32'hDEADBEEF);
        run(32'h12345678, 32'h0000000F, 19, 1'b0, 1'b0, 5'd9, 3,  1'b1, 1'b1, 32'd0);
        chk("illegal_kept", {31'd0, o_illegal}, 32'd1);
        run(32'h00002000, 32'h00000FF8, 10, 1'b1, 1'b0, 5'd2, 0,  1'b0, 1'b1, 32'h00001FF8);
        chk("illegal_cleared", {31'd0, o_illegal}, 32'd0);
        run(32'd3,        32'd4,        0,  1'b0, 1'b0, 5'd0, 0,  1'b0, 1'b0, 32'd0);

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 9) < 8) op = int'($urandom_range(0, 20));
            else                          op = int'($urandom_range(19, 31));
            case ($urandom_range(0, 3))
                0:       a = 32'h80000000;
                1:       a = 32'hFFFFFFFF;
                default: a = $urandom;
            endcase
            b  = ($urandom_range(0, 1) == 1) ? $urandom : {20'd0, 12'($urandom)};
            rd = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom);
            run(a, b, op, (op == 10) && ($urandom_range(0, 1) == 1), op == 20, rd,
                int'($urandom_range(0, 3)), 1'b0, 1'b0, 32'd0);
        end

        // Reset while holding a result: everything clears, no flush follows
        i_operand1 = 32'd1; i_operand2 = 32'd2; i_ALUop = 5'd0;
        i_mem_read = 1'b0; i_mem_write = 1'b0; i_rd = 5'd1;
        i_dec_ins_ready = 1'b1;
        step(); step(); step();
        chk("pre_rst_valid", {31'd0, o_ex_valid}, 32'd1);
        step();
        rst = 1'b1;
        i_dec_ins_ready = 1'b0;
        step();
        rst = 1'b0;
        exp_count = 0;
        chk("hold_rst_valid", {31'd0, o_ex_valid}, 32'd0);
        chk("hold_rst_result", o_result, 32'd0);
        chk("hold_rst_reg_write", {31'd0, o_reg_write}, 32'd0);
        chk("hold_rst_rd", {27'd0, o_rd}, 32'd0);
        chk("hold_rst_count", {16'd0, o_ex_count}, 32'd0);
        chk("hold_rst_flush", {31'd0, o_flush}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("post_rst_flush", {31'd0, o_flush}, 32'd0);
        end
        run(32'd100, 32'd23, 1, 1'b0, 1'b0, 5'd31, 0, 1'b0, 1'b1, 32'd77);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
